sprite_draw_controller: RTL and testbench

Sequencer that owns the VGA plot path for one 160x120 frame update. On a start request it walks the 15-bit background-screen ROM address space (19200 pixels) and then the 11-bit sprite ROM address space (1600 pixels, 40x40). It emits pixel coordinates, colour and a plot strobe to the VGA adapter, then holds until the next 4 Hz frame tick. It sits between the game FSM (start and position) and the screen/sprite ROMs plus the 4 Hz delay generator.

---
 rtl/sprite_draw_controller.sv | 156 +++++++++++++++
 tb/tb_sprite_draw_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_controller.sv
// Frame-update sequencer: walks the background ROM and then the sprite ROM, and emits
// one VGA plot per cycle. After the draw it holds until the next frame tick.
module sprite_draw_controller #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         SPRITE_W    = 40,
  parameter int         SPRITE_H    = 40,
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic        clk,
  input  logic        drawControllerReset,
  input  logic        start,
  input  logic        drawBackground,
  input  logic [7:0]  spriteX,
  input  logic [6:0]  spriteY,
  input  logic        frameTick,
  input  logic [2:0]  screenData,
  input  logic [2:0]  spriteData,
  output logic [14:0] screenAddr,
  output logic [10:0] spriteAddr,
  output logic [7:0]  plotX,
  output logic [6:0]  plotY,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int         SCREEN_PIX = SCREEN_W * SCREEN_H;
  localparam int         SPRITE_PIX = SPRITE_W * SPRITE_H;
  localparam logic [7:0] MAX_X      = 8'(SCREEN_W - SPRITE_W);
  localparam logic [6:0] MAX_Y      = 7'(SCREEN_H - SPRITE_H);

  typedef enum logic [2:0] {S_IDLE, S_BG, S_SPRITE, S_FLUSH, S_HOLD} state_t;

  state_t      r_state, w_state_next;
  logic [14:0] r_screen_addr;
  logic [10:0] r_sprite_addr;
  logic [7:0]  r_bx;
  logic [6:0]  r_by;
  logic [5:0]  r_sx, r_sy;
  logic [7:0]  r_pos_x;
  logic [6:0]  r_pos_y;
  logic        r_pix_valid, r_pix_sprite;
  logic [7:0]  r_plot_x;
  logic [6:0]  r_plot_y;
  logic        r_done;

  logic        w_last_bg, w_last_spr;
  logic [7:0]  w_clamp_x;
  logic [6:0]  w_clamp_y;

  assign w_last_bg  = (r_screen_addr == 15'(SCREEN_PIX - 1));
  assign w_last_spr = (r_sprite_addr == 11'(SPRITE_PIX - 1));
  assign w_clamp_x  = (spriteX > MAX_X) ? MAX_X : spriteX;
  assign w_clamp_y  = (spriteY > MAX_Y) ? MAX_Y : spriteY;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = drawBackground ? S_BG : S_SPRITE;
      S_BG:     if (w_last_bg) w_state_next = S_SPRITE;
      S_SPRITE: if (w_last_spr) w_state_next = S_FLUSH;
      S_FLUSH:  w_state_next = S_HOLD;
      S_HOLD:   if (frameTick) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge drawControllerReset) begin
    if (!drawControllerReset) r_state <= S_IDLE;
    else                      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge drawControllerReset) begin
    if (!drawControllerReset) begin
      r_screen_addr <= '0;
      r_sprite_addr <= '0;
      r_bx          <= '0;
      r_by          <= '0;
      r_sx          <= '0;
      r_sy          <= '0;
      r_pos_x       <= '0;
      r_pos_y       <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_sprite  <= 1'b0;
      r_plot_x      <= '0;
      r_plot_y      <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done <= (r_state == S_HOLD) && frameTick;

      if (r_state == S_IDLE && start) begin
        r_pos_x <= w_clamp_x;
        r_pos_y <= w_clamp_y;
      end

      // Address and coordinate counters advance in lockstep; no multiplier needed.
      if (r_state == S_BG) begin
        if (w_last_bg) begin
          r_screen_addr <= '0;
          r_bx          <= '0;
          r_by          <= '0;
        end else begin
          r_screen_addr <= r_screen_addr + 15'd1;
          if (r_bx == 8'(SCREEN_W - 1)) begin
            r_bx <= '0;
            r_by <= r_by + 7'd1;
          end else begin
            r_bx <= r_bx + 8'd1;
          end
        end
      end

      if (r_state == S_SPRITE) begin
        if (w_last_spr) begin
          r_sprite_addr <= '0;
          r_sx          <= '0;
          r_sy          <= '0;
        end else begin
          r_sprite_addr <= r_sprite_addr + 11'd1;
          if (r_sx == 6'(SPRITE_W - 1)) begin
            r_sx <= '0;
            r_sy <= r_sy + 6'd1;
          end else begin
            r_sx <= r_sx + 6'd1;
          end
        end
      end

      r_pix_valid  <= (r_state == S_BG) || (r_state == S_SPRITE);
      r_pix_sprite <= (r_state == S_SPRITE);
      if (r_state == S_BG) begin
        r_plot_x <= r_bx;
        r_plot_y <= r_by;
      end else if (r_state == S_SPRITE) begin
        r_plot_x <= r_pos_x + {2'b00, r_sx};
        r_plot_y <= r_pos_y + {1'b0, r_sy};
      end else begin
        r_plot_x <= '0;
        r_plot_y <= '0;
      end
    end
  end

  // ROM data arrives in the pixel's own cycle, so colour/plot are gated combinationally.
  assign colour     = !r_pix_valid ? 3'b000 : (r_pix_sprite ? spriteData : screenData);
  assign plot       = r_pix_valid && (!r_pix_sprite || (spriteData != TRANSPARENT));
  assign screenAddr = r_screen_addr;
  assign spriteAddr = r_sprite_addr;
  assign plotX      = r_plot_x;
  assign plotY      = r_plot_y;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_sprite_draw_controller.sv
// Randomised scoreboard bench for sprite_draw_controller with behavioural ROM and pixel model.
module tb_sprite_draw_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, drawBackground, frameTick;
  logic [7:0]  spriteX;
  logic [6:0]  spriteY;
  logic [2:0]  screenData, spriteData;
  logic [14:0] screenAddr;
  logic [10:0] spriteAddr;
  logic [7:0]  plotX;
  logic [6:0]  plotY;
  logic [2:0]  colour;
  logic        plot, busy, done;

  sprite_draw_controller dut (
    .clk                 (clk),
    .drawControllerReset (rst_n),
    .start               (start),
    .drawBackground      (drawBackground),
    .spriteX             (spriteX),
    .spriteY             (spriteY),
    .frameTick           (frameTick),
    .screenData          (screenData),
    .spriteData          (spriteData),
    .screenAddr          (screenAddr),
    .spriteAddr          (spriteAddr),
    .plotX               (plotX),
    .plotY               (plotY),
    .colour              (colour),
    .plot                (plot),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] scr_rom [19200];
  logic [2:0] spr_rom [1600];
  always @(posedge clk) begin
    screenData <= scr_rom[screenAddr];
    spriteData <= spr_rom[spriteAddr];
  end

  typedef struct {int x; int y; int c; int t;} pix_t;
  pix_t exp_q[$];

  int n_checks = 0, n_pass = 0, n_fail_prints = 0;
  int plot_cnt = 0, done_cnt = 0, last_done_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && plot === 1'b1) begin
      plot_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_plot: (%0d,%0d) c=%0d at cycle %0d, expected none",
                 plotX, plotY, colour, cyc);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if (int'(plotX) == e.x && int'(plotY) == e.y && int'(colour) == e.c && cyc == e.t)
          n_pass++;
        else if (n_fail_prints < 20) begin
          n_fail_prints++;
          $display("FAIL pixel: got (%0d,%0d) c=%0d cycle %0d, expected (%0d,%0d) c=%0d cycle %0d",
                   plotX, plotY, colour, cyc, e.x, e.y, e.c, e.t);
        end
      end
    end
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expected plot stream: raster order, one pixel per cycle starting two cycles after start.
  task automatic push_model(input bit bg, input int x_in, input int y_in, input int t0,
                            output int count);
    int t, px, py, c;
    t = t0 + 2;
    count = 0;
    if (bg) begin
      for (int y = 0; y < 120; y++)
        for (int x = 0; x < 160; x++) begin
          exp_q.push_back('{x, y, int'(scr_rom[y * 160 + x]), t});
          t++;
          count++;
        end
    end
    px = (x_in > 120) ? 120 : x_in;
    py = (y_in > 80) ? 80 : y_in;
    for (int sy = 0; sy < 40; sy++)
      for (int sx = 0; sx < 40; sx++) begin
        c = int'(spr_rom[sy * 40 + sx]);
        if (c != 0) begin
          exp_q.push_back('{px + sx, py + sy, c, t});
          count++;
        end
        t++;
      end
  endtask

  task automatic run_draw(input bit bg, input int x, input int y, input int tick_at,
                          input int spur_tick, input bit extra_starts, input bit hold,
                          input bit cont);
    int t0, n_exp, p0, d0, k;
    if (!cont) step();
    drawBackground = bg;
    spriteX = 8'(x);
    spriteY = 7'(y);
    start = 1'b1;
    t0 = cyc;
    p0 = plot_cnt;
    d0 = done_cnt;
    push_model(bg, x, y, t0, n_exp);
    step();
    start = hold;
    chk("busy_rise", busy, 1);
    chk("first_addr", bg ? int'(screenAddr) : int'(spriteAddr), 0);
    if (!hold) begin
      drawBackground = 1'($urandom_range(0, 1));
      spriteX = 8'($urandom_range(0, 255));
      spriteY = 7'($urandom_range(0, 127));
    end
    do begin
      step();
      k = cyc - t0;
      start = hold || (extra_starts && (k == 50 || k == 500));
      frameTick = (k == tick_at) || (k == spur_tick);
    end while (k < tick_at);
    step();
    frameTick = 1'b0;
    start = hold;
    chk("done_count", done_cnt - d0, 1);
    chk("done_cycle", last_done_cyc - t0, tick_at + 1);
    chk("busy_fall", busy, 0);
    chk("plot_count", plot_cnt - p0, n_exp);
    chk("queue_drained", exp_q.size(), 0);
    $display("draw bg=%0d pos=(%0d,%0d) tick=%0d plots=%0d done_at=%0d",
             bg, x, y, tick_at, plot_cnt - p0, last_done_cyc - t0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_screenAddr"}, screenAddr, 0);
    chk({tag, "_spriteAddr"}, spriteAddr, 0);
    chk({tag, "_plotX"}, plotX, 0);
    chk({tag, "_plotY"}, plotY, 0);
    chk({tag, "_colour"}, colour, 0);
    chk({tag, "_plot"}, plot, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic fill_sprite(input bit even_transparent);
    for (int i = 0; i < 1600; i++) begin
      if (even_transparent) spr_rom[i] = (i % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      else                  spr_rom[i] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    end
  endtask

  initial begin
    int n_dummy, p0, w;
    rst_n = 1'b0;
    start = 1'b0;
    drawBackground = 1'b0;
    frameTick = 1'b0;
    spriteX = '0;
    spriteY = '0;
    for (int i = 0; i < 19200; i++) scr_rom[i] = 3'($urandom_range(0, 7));
    fill_sprite(1'b0);

    repeat (3) step();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();
    check_outputs_zero("post_reset");

    run_draw(1'b1, 10, 20, 25000, -1, 1'b1, 1'b0, 1'b0);

    fill_sprite(1'b1);
    run_draw(1'b0, 200, 100, 1700, 1000, 1'b1, 1'b0, 1'b0);

    fill_sprite(1'b0);
    w = $urandom_range(0, 255);
    p0 = $urandom_range(0, 127);
    run_draw(1'b0, w, p0, 1650, -1, 1'b0, 1'b1, 1'b0);
    run_draw(1'b0, w, p0, 1620, -1, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      fill_sprite(1'b0);
      run_draw(1'b0, $urandom_range(0, 255), $urandom_range(0, 127),
               1602 + $urandom_range(0, 20), -1, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of the background pass.
    step();
    drawBackground = 1'b1;
    spriteX = 8'd30;
    spriteY = 7'd40;
    start = 1'b1;
    push_model(1'b1, 30, 40, cyc, n_dummy);
    step();
    start = 1'b0;
    w = 0;
    while (screenAddr != 15'd5000 && w < 6000) begin
      step();
      w++;
    end
    chk("reach_addr_5000", screenAddr, 5000);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) step();
    rst_n = 1'b1;
    p0 = plot_cnt;
    repeat (50) step();
    chk("no_plot_after_reset", plot_cnt - p0, 0);
    chk("idle_after_reset", busy, 0);
    $display("reset mid-draw at screenAddr=5000, plots after release=%0d", plot_cnt - p0);

    run_draw(1'b0, 5, 7, 1610, -1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
